// File: rtl/bf16_pack_out.sv
// bf16_pack_out: converts 128-bit beats of four fp32 lanes to bf16
// (round-to-nearest-even) and packs pairs of converted beats into
// 128-bit result-buffer words, one write per pair.
module bf16_pack_out #(
  parameter int DATA_NUM = 192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stage_start,
  input  logic         in_tvalid,
  input  logic [127:0] in_tdata,
  output logic         out_wr_en,
  output logic [6:0]   out_addr,
  output logic [127:0] out_wdata,
  output logic         busy,
  output logic         stage_done,
  output logic         err_extra
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] NUM8  = 8'(DATA_NUM);
  localparam logic [7:0] LAST8 = 8'(DATA_NUM - 1);

  // fp32 -> bf16, round-to-nearest-even; NaN collapses to a quiet NaN
  // with the sign kept. Carry out of the mantissa may reach infinity.
  function automatic logic [15:0] rne_bf16(input logic [31:0] f);
    logic        round_up;
    logic [15:0] res;
    round_up = f[15] & ((|f[14:0]) | f[16]);
    if ((&f[30:23]) && (|f[22:0]))
      res = {f[31], 8'hFF, 7'h40};
    else
      res = f[31:16] + {15'd0, round_up};
    return res;
  endfunction

  // Converts all four lanes of a beat, lane0 in the low 16 bits.
  function automatic logic [63:0] cvt_beat(input logic [127:0] d);
    logic [63:0] res;
    res = '0;
    for (int i = 0; i < 4; i++)
      res[16*i +: 16] = rne_bf16(d[32*i +: 32]);
    return res;
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic        ss_q;
  logic [7:0]  beat_cnt;
  logic [6:0]  word_cnt;
  logic [63:0] hold_p1;
  logic [63:0] cvt_p0;
  logic        vld_p0;
  logic        odd_p0;
  logic        last_p0;

  logic        stage_open;
  logic        accept;
  logic        drop;
  logic        pair_go;
  logic        final_wr;

  // Next-state and per-cycle control decode.
  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    stage_open = 1'b0;
    accept     = 1'b0;
    drop       = 1'b0;
    pair_go    = 1'b0;
    final_wr   = 1'b0;
    case (state)
      IDLE: begin
        stage_open = stage_start & ~ss_q;
        drop       = in_tvalid;
        if (stage_open)
          state_nxt = ACTIVE;
      end
      ACTIVE: begin
        busy = 1'b1;
        if (!stage_start) begin
          // Abort: in-flight beats and the pending pair are discarded.
          state_nxt = IDLE;
        end else begin
          accept   = in_tvalid & (beat_cnt < NUM8);
          drop     = in_tvalid & (beat_cnt == NUM8);
          pair_go  = vld_p0;
          final_wr = vld_p0 & last_p0;
          if (final_wr)
            state_nxt = DONE;
        end
      end
      DONE: begin
        drop      = in_tvalid;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Registered copy of stage_start for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst)
      ss_q <= 1'b0;
    else
      ss_q <= stage_start;
  end

  // Beat counter and sticky dropped-beat flag; a new stage clears both.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      err_extra <= 1'b0;
    end else if (stage_open) begin
      beat_cnt  <= '0;
      err_extra <= 1'b0;
    end else begin
      if (accept)
        beat_cnt <= beat_cnt + 8'd1;
      if (drop)
        err_extra <= 1'b1;
    end
  end

  // ---- stage p0: convert accepted beat, tag its parity and last-ness ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      cvt_p0  <= '0;
      odd_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        cvt_p0  <= cvt_beat(in_tdata);
        odd_p0  <= beat_cnt[0];
        last_p0 <= (beat_cnt == LAST8);
      end
    end
  end

  // ---- stage p1: pair even/odd beats and issue the buffer write ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_wr_en <= 1'b0;
      out_addr  <= '0;
      out_wdata <= '0;
      hold_p1   <= '0;
      word_cnt  <= '0;
    end else begin
      out_wr_en <= 1'b0;
      if (stage_open) begin
        word_cnt <= '0;
        hold_p1  <= '0;
      end else if (pair_go) begin
        if (odd_p0) begin
          out_wr_en <= 1'b1;
          out_addr  <= word_cnt;
          out_wdata <= {cvt_p0, hold_p1};
          word_cnt  <= word_cnt + 7'd1;
        end else if (last_p0) begin
          // Odd beat count: the lone final beat goes out unpaired.
          out_wr_en <= 1'b1;
          out_addr  <= word_cnt;
          out_wdata <= {64'd0, cvt_p0};
          word_cnt  <= word_cnt + 7'd1;
        end else begin
          hold_p1 <= cvt_p0;
        end
      end
    end
  end

  // Completion pulse in the cycle after the final write.
  always_ff @(posedge clk) begin
    if (rst)
      stage_done <= 1'b0;
    else
      stage_done <= (state == DONE);
  end

endmodule
